// File: rtl/mem_arbiter.sv
// Arbitrates one single-port memory between a CPU and a DMA requester; CPU has priority, DMA bounded starvation.
// Optional MEMARB_FAST_WRITE_EN: writes finish after a single ACCESS cycle regardless of RD_LAT.
module mem_arbiter #(
  parameter int AW       = 18,
  parameter int DW       = 8,
  parameter int RD_LAT   = 1,
  parameter int MAX_WAIT = 4
) (
  input  logic          clock,
  input  logic          resetn,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  output logic          cpu_ack,
  output logic [DW-1:0] cpu_rdata,
  input  logic          dma_req,
  input  logic          dma_we,
  input  logic [AW-1:0] dma_addr,
  input  logic [DW-1:0] dma_wdata,
  output logic          dma_ack,
  output logic [DW-1:0] dma_rdata,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_data,
  output logic          mem_wren,
  input  logic [DW-1:0] mem_q,
  output logic [1:0]    grant
);

  localparam int LCW = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
  localparam int WCW = $clog2(MAX_WAIT + 1);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t          state_reg, state_next;
  logic            owner_dma_reg, owner_dma_next;
  logic            we_reg, we_next;
  logic [LCW-1:0]  lat_cnt_reg, lat_cnt_next;
  logic [WCW-1:0]  wait_cnt_reg, wait_cnt_next;
  logic [AW-1:0]   addr_reg, addr_next;
  logic [DW-1:0]   data_reg, data_next;
  logic            wren_reg, wren_next;
  logic [1:0]      grant_reg, grant_next;
  logic            cpu_ack_reg, cpu_ack_next;
  logic            dma_ack_reg, dma_ack_next;
  logic [DW-1:0]   cpu_rdata_reg, cpu_rdata_next;
  logic [DW-1:0]   dma_rdata_reg, dma_rdata_next;
  logic            dma_win;
  logic            access_done;

  // DMA wins when alone, or when the CPU has already beaten it MAX_WAIT times in a row
  assign dma_win = dma_req && (!cpu_req || (wait_cnt_reg == WCW'(MAX_WAIT)));

`ifdef MEMARB_FAST_WRITE_EN
  assign access_done = we_reg || (lat_cnt_reg == LCW'(RD_LAT - 1));
`else
  assign access_done = (lat_cnt_reg == LCW'(RD_LAT - 1));
`endif

  always_ff @(posedge clock) begin
    if (!resetn) begin
      state_reg     <= IDLE;
      owner_dma_reg <= 1'b0;
      we_reg        <= 1'b0;
      lat_cnt_reg   <= '0;
      wait_cnt_reg  <= '0;
      addr_reg      <= '0;
      data_reg      <= '0;
      wren_reg      <= 1'b0;
      grant_reg     <= 2'b00;
      cpu_ack_reg   <= 1'b0;
      dma_ack_reg   <= 1'b0;
      cpu_rdata_reg <= '0;
      dma_rdata_reg <= '0;
    end else begin
      state_reg     <= state_next;
      owner_dma_reg <= owner_dma_next;
      we_reg        <= we_next;
      lat_cnt_reg   <= lat_cnt_next;
      wait_cnt_reg  <= wait_cnt_next;
      addr_reg      <= addr_next;
      data_reg      <= data_next;
      wren_reg      <= wren_next;
      grant_reg     <= grant_next;
      cpu_ack_reg   <= cpu_ack_next;
      dma_ack_reg   <= dma_ack_next;
      cpu_rdata_reg <= cpu_rdata_next;
      dma_rdata_reg <= dma_rdata_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    owner_dma_next = owner_dma_reg;
    we_next        = we_reg;
    lat_cnt_next   = lat_cnt_reg;
    wait_cnt_next  = wait_cnt_reg;
    addr_next      = addr_reg;
    data_next      = data_reg;
    wren_next      = wren_reg;
    grant_next     = grant_reg;
    cpu_ack_next   = cpu_ack_reg;
    dma_ack_next   = dma_ack_reg;
    cpu_rdata_next = cpu_rdata_reg;
    dma_rdata_next = dma_rdata_reg;

    case (state_reg)
      IDLE: begin
        if (!dma_req || dma_win) begin
          wait_cnt_next = '0;
        end else if (wait_cnt_reg != WCW'(MAX_WAIT)) begin
          wait_cnt_next = wait_cnt_reg + WCW'(1);
        end
        if (cpu_req || dma_req) begin
          owner_dma_next = dma_win;
          we_next        = dma_win ? dma_we    : cpu_we;
          addr_next      = dma_win ? dma_addr  : cpu_addr;
          data_next      = dma_win ? dma_wdata : cpu_wdata;
          wren_next      = dma_win ? dma_we    : cpu_we;
          grant_next     = dma_win ? 2'b10     : 2'b01;
          lat_cnt_next   = '0;
          state_next     = ACCESS;
        end
      end
      ACCESS: begin
        wren_next = 1'b0;
        if (access_done) begin
          if (owner_dma_reg) begin
            dma_ack_next = 1'b1;
            if (!we_reg) dma_rdata_next = mem_q;
          end else begin
            cpu_ack_next = 1'b1;
            if (!we_reg) cpu_rdata_next = mem_q;
          end
          state_next = RESP;
        end else begin
          lat_cnt_next = lat_cnt_reg + LCW'(1);
        end
      end
      RESP: begin
        cpu_ack_next = 1'b0;
        dma_ack_next = 1'b0;
        grant_next   = 2'b00;
        state_next   = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign cpu_ack   = cpu_ack_reg;
  assign cpu_rdata = cpu_rdata_reg;
  assign dma_ack   = dma_ack_reg;
  assign dma_rdata = dma_rdata_reg;
  assign mem_addr  = addr_reg;
  assign mem_data  = data_reg;
  assign mem_wren  = wren_reg;
  assign grant     = grant_reg;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed vector table, corner-case sequences, RD_LAT=3 instance,
// and a randomized run against a transaction-level reference model.
module tb_mem_arbiter;

  localparam int MAX_WAIT = 4;
  localparam int RD_LAT   = 1;
  localparam int NCYC     = 1500;
`ifdef MEMARB_FAST_WRITE_EN
  localparam int L3_WR_ACK = 2;
`else
  localparam int L3_WR_ACK = 4;
`endif

  logic        clock, resetn;
  logic        cpu_req, cpu_we, cpu_ack;
  logic [17:0] cpu_addr;
  logic [7:0]  cpu_wdata, cpu_rdata;
  logic        dma_req, dma_we, dma_ack;
  logic [17:0] dma_addr;
  logic [7:0]  dma_wdata, dma_rdata;
  logic [17:0] mem_addr;
  logic [7:0]  mem_data, mem_q;
  logic        mem_wren;
  logic [1:0]  grant;

  logic        l3_req, l3_we, l3_ack, l3_dack, l3_mwren;
  logic [17:0] l3_addr, l3_maddr;
  logic [7:0]  l3_wdata, l3_rdata, l3_drdata, l3_mdata, l3_mq;
  logic [1:0]  l3_grant;

  int checks = 0;
  int errors = 0;

  mem_arbiter #(.AW(18), .DW(8), .RD_LAT(RD_LAT), .MAX_WAIT(MAX_WAIT)) dut (
    .clock(clock), .resetn(resetn),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata),
    .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
    .dma_ack(dma_ack), .dma_rdata(dma_rdata),
    .mem_addr(mem_addr), .mem_data(mem_data), .mem_wren(mem_wren), .mem_q(mem_q),
    .grant(grant)
  );

  mem_arbiter #(.AW(18), .DW(8), .RD_LAT(3), .MAX_WAIT(MAX_WAIT)) dut_l3 (
    .clock(clock), .resetn(resetn),
    .cpu_req(l3_req), .cpu_we(l3_we), .cpu_addr(l3_addr), .cpu_wdata(l3_wdata),
    .cpu_ack(l3_ack), .cpu_rdata(l3_rdata),
    .dma_req(1'b0), .dma_we(1'b0), .dma_addr(18'h0), .dma_wdata(8'h0),
    .dma_ack(l3_dack), .dma_rdata(l3_drdata),
    .mem_addr(l3_maddr), .mem_data(l3_mdata), .mem_wren(l3_mwren), .mem_q(l3_mq),
    .grant(l3_grant)
  );

  function automatic logic [7:0] pat(input logic [17:0] a);
    if (a == 18'h00123) return 8'h5A;
    return a[7:0] ^ a[15:8] ^ {6'b0, a[17:16]} ^ 8'h3C;
  endfunction

  // Memories: contents are a known pattern, filled on the first clock edge
  logic [7:0] env_mem [0:262143];
  logic [7:0] l3_mem  [0:255];
  bit mem_ready = 1'b0;
  always @(posedge clock) begin
    if (!mem_ready) begin
      for (int i = 0; i < 262144; i++) env_mem[i] <= pat(18'(i));
      for (int i = 0; i < 256; i++) l3_mem[i] <= pat(18'(i));
      mem_ready <= 1'b1;
    end else begin
      if (mem_wren) env_mem[mem_addr] <= mem_data;
      if (l3_mwren) l3_mem[l3_maddr[7:0]] <= l3_mdata;
    end
  end
  assign mem_q = env_mem[mem_addr];
  assign l3_mq = l3_mem[l3_maddr[7:0]];

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached, got no finish expected finish");
    $fatal(1, "timeout");
  end

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // One CPU transaction on the RD_LAT=1 instance, started in an IDLE cycle (cycle 0)
  task automatic cpu_txn(input logic we, input logic [17:0] addr, input logic [7:0] wdata,
                         input logic [7:0] exp_rd);
    cpu_we = we; cpu_addr = addr; cpu_wdata = wdata; cpu_req = 1'b1;
    tick;
    chk("c1_grant", grant, 2'b01);
    chk("c1_addr", mem_addr, addr);
    chk("c1_wren", mem_wren, we);
    if (we) chk("c1_data", mem_data, wdata);
    chk("c1_ack", cpu_ack, 1'b0);
    tick;
    chk("c2_ack", cpu_ack, 1'b1);
    chk("c2_grant", grant, 2'b01);
    chk("c2_wren", mem_wren, 1'b0);
    chk("c2_rdata", cpu_rdata, exp_rd);
    chk("c2_dma_ack", dma_ack, 1'b0);
    tick;
    cpu_req = 1'b0;
    chk("c3_grant", grant, 2'b00);
    chk("c3_ack", cpu_ack, 1'b0);
    chk("c3_rdata", cpu_rdata, exp_rd);
  endtask

  task automatic l3_txn(input string name, input logic we, input logic [17:0] addr,
                        input logic [7:0] wdata, input int exp_cyc, input logic [7:0] exp_rd);
    int cyc;
    cyc = 0;
    l3_we = we; l3_addr = addr; l3_wdata = wdata; l3_req = 1'b1;
    while (cyc < 12) begin
      tick;
      cyc++;
      if (l3_ack) break;
    end
    chk({name, "_ack_cycle"}, cyc, exp_cyc);
    chk({name, "_rdata"}, l3_rdata, exp_rd);
    tick;
    l3_req = 1'b0;
    chk({name, "_grant_idle"}, l3_grant, 2'b00);
    $display("l3 txn %s we=%0d addr=%05h ack_cycle=%0d rdata=%02h", name, we, addr, cyc, l3_rdata);
  endtask

  typedef struct {
    logic        we;
    logic [17:0] addr;
    logic [7:0]  wdata;
    logic [7:0]  exp_rd;
  } vec_t;
  vec_t tbl [6];

  // Reference-model state for the randomized run
  bit         exp_cack [0:NCYC+15];
  bit         exp_dack [0:NCYC+15];
  bit         exp_wren [0:NCYC+15];
  logic [1:0] exp_gnt  [0:NCYC+15];
  logic [7:0] ref_w [16];
  int         m_free, wc_m, lat_m, ack_m, idx_m;
  bit         cpend, dpend, take_dma, we_m, c_rd, d_rd;
  logic [7:0] c_val, d_val, exp_crd, exp_drd, wd_m;
  logic [17:0] addr_m;

  function automatic int txn_lat(input bit we);
`ifdef MEMARB_FAST_WRITE_EN
    if (we) return 1;
`endif
    return RD_LAT;
  endfunction

  initial begin
    tbl[0] = '{1'b0, 18'h00123, 8'h00, 8'h5A};
    tbl[1] = '{1'b1, 18'h3FFFF, 8'hC3, 8'h5A};
    tbl[2] = '{1'b0, 18'h3FFFF, 8'h00, 8'hC3};
    tbl[3] = '{1'b1, 18'h00200, 8'h77, 8'hC3};
    tbl[4] = '{1'b0, 18'h00200, 8'h00, 8'h77};
    tbl[5] = '{1'b0, 18'h00123, 8'h00, 8'h5A};

    resetn = 1'b0;
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 18'h1; cpu_wdata = 8'hFF;
    dma_req = 1'b1; dma_we = 1'b1; dma_addr = 18'h2; dma_wdata = 8'hEE;
    l3_req = 1'b0; l3_we = 1'b0; l3_addr = 18'h0; l3_wdata = 8'h0;
    repeat (4) tick;
    chk("rst_grant", grant, 2'b00);
    chk("rst_cpu_ack", cpu_ack, 1'b0);
    chk("rst_dma_ack", dma_ack, 1'b0);
    chk("rst_wren", mem_wren, 1'b0);
    chk("rst_addr", mem_addr, 18'h0);
    chk("rst_data", mem_data, 8'h0);
    chk("rst_cpu_rdata", cpu_rdata, 8'h0);
    chk("rst_dma_rdata", dma_rdata, 8'h0);
    cpu_req = 1'b0; dma_req = 1'b0;
    resetn = 1'b1;
    tick;

    // Directed CPU vectors, issued back to back
    for (int i = 0; i < 6; i++) begin
      cpu_txn(tbl[i].we, tbl[i].addr, tbl[i].wdata, tbl[i].exp_rd);
      $display("cpu txn %0d we=%0d addr=%05h wdata=%02h rdata=%02h", i, tbl[i].we,
               tbl[i].addr, tbl[i].wdata, cpu_rdata);
    end

    // Both requesting continuously: four CPU grants then one DMA grant, repeating
    cpu_we = 1'b0; cpu_addr = 18'h00040; dma_we = 1'b0; dma_addr = 18'h00050;
    cpu_req = 1'b1; dma_req = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick;
      chk("fair_grant", grant, (i % 5 == 4) ? 2'b10 : 2'b01);
      tick;
      chk("fair_cpu_ack", cpu_ack, (i % 5 == 4) ? 1'b0 : 1'b1);
      chk("fair_dma_ack", dma_ack, (i % 5 == 4) ? 1'b1 : 1'b0);
      $display("fair txn %0d grant=%b", i, grant);
      tick;
    end
    cpu_req = 1'b0; dma_req = 1'b0;
    tick;

    // DMA alone, three back-to-back reads
    dma_we = 1'b0; dma_addr = 18'h00010; dma_req = 1'b1;
    for (int c = 1; c <= 9; c++) begin
      tick;
      chk("dma_ack_cadence", dma_ack, (c % 3 == 2) ? 1'b1 : 1'b0);
      chk("dma_cpu_ack_quiet", cpu_ack, 1'b0);
      if (c % 3 == 2) begin
        chk("dma_rdata", dma_rdata, pat(dma_addr));
        $display("dma txn addr=%05h rdata=%02h", dma_addr, dma_rdata);
      end
      if (c % 3 == 0) begin
        if (c < 9) dma_addr = dma_addr + 18'h1;
        else dma_req = 1'b0;
      end
    end

    // Reset during ACCESS of a CPU write abandons it
    cpu_we = 1'b1; cpu_addr = 18'h00300; cpu_wdata = 8'hA5; cpu_req = 1'b1;
    tick;
    chk("abort_wren_before", mem_wren, 1'b1);
    resetn = 1'b0;
    tick;
    chk("abort_wren", mem_wren, 1'b0);
    chk("abort_grant", grant, 2'b00);
    chk("abort_ack", cpu_ack, 1'b0);
    resetn = 1'b1; cpu_req = 1'b0;
    tick;
    chk("abort_ack_after", cpu_ack, 1'b0);
    chk("abort_grant_after", grant, 2'b00);
    cpu_txn(1'b0, 18'h00123, 8'h00, 8'h5A);
    $display("post-abort txn read 00123 rdata=%02h", cpu_rdata);

    // RD_LAT=3 instance
    l3_txn("l3_read", 1'b0, 18'h00040, 8'h00, 4, pat(18'h00040));
    l3_txn("l3_write", 1'b1, 18'h00041, 8'h9C, L3_WR_ACK, pat(18'h00040));
    l3_txn("l3_readback", 1'b0, 18'h00041, 8'h00, 4, 8'h9C);

    // Randomized traffic against the transaction-level model
    for (int i = 0; i < NCYC + 16; i++) begin
      exp_cack[i] = 1'b0; exp_dack[i] = 1'b0; exp_wren[i] = 1'b0; exp_gnt[i] = 2'b00;
    end
    for (int i = 0; i < 16; i++) ref_w[i] = pat(18'h20000 + 18'(i));
    cpu_req = 1'b0; dma_req = 1'b0; resetn = 1'b0;
    tick; tick;
    resetn = 1'b1;
    m_free = 0; wc_m = 0; cpend = 1'b0; dpend = 1'b0;
    exp_crd = 8'h0; exp_drd = 8'h0; c_rd = 1'b0; d_rd = 1'b0; c_val = 8'h0; d_val = 8'h0;
    for (int k = 0; k < NCYC; k++) begin
      if (k > 0) tick;
      if (exp_cack[k] && c_rd) exp_crd = c_val;
      if (exp_dack[k] && d_rd) exp_drd = d_val;
      chk($sformatf("rnd_grant@%0d", k), grant, exp_gnt[k]);
      chk($sformatf("rnd_cpu_ack@%0d", k), cpu_ack, exp_cack[k]);
      chk($sformatf("rnd_dma_ack@%0d", k), dma_ack, exp_dack[k]);
      chk($sformatf("rnd_wren@%0d", k), mem_wren, exp_wren[k]);
      chk($sformatf("rnd_cpu_rdata@%0d", k), cpu_rdata, exp_crd);
      chk($sformatf("rnd_dma_rdata@%0d", k), dma_rdata, exp_drd);

      if (k > 0 && exp_cack[k-1]) cpend = 1'b0;
      if (k > 0 && exp_dack[k-1]) dpend = 1'b0;
      if (!cpend && $urandom_range(0, 99) < 50) begin
        cpend = 1'b1;
        cpu_we = 1'($urandom_range(0, 1));
        cpu_addr = 18'h20000 + 18'($urandom_range(0, 15));
        cpu_wdata = 8'($urandom);
      end
      if (!dpend && $urandom_range(0, 99) < 40) begin
        dpend = 1'b1;
        dma_we = 1'($urandom_range(0, 1));
        dma_addr = 18'h20000 + 18'($urandom_range(0, 15));
        dma_wdata = 8'($urandom);
      end
      cpu_req = cpend;
      dma_req = dpend;

      if (k >= m_free) begin
        if (cpu_req && dma_req) begin
          if (wc_m < MAX_WAIT) begin take_dma = 1'b0; wc_m++; end
          else begin take_dma = 1'b1; wc_m = 0; end
        end else begin
          take_dma = dma_req;
          wc_m = 0;
        end
        if (cpu_req || dma_req) begin
          we_m   = take_dma ? dma_we : cpu_we;
          addr_m = take_dma ? dma_addr : cpu_addr;
          wd_m   = take_dma ? dma_wdata : cpu_wdata;
          lat_m  = txn_lat(we_m);
          ack_m  = k + lat_m + 1;
          for (int j = k + 1; j <= ack_m; j++) exp_gnt[j] = take_dma ? 2'b10 : 2'b01;
          exp_wren[k+1] = we_m;
          idx_m = int'(addr_m[3:0]);
          if (take_dma) begin
            exp_dack[ack_m] = 1'b1; d_rd = !we_m; d_val = ref_w[idx_m];
          end else begin
            exp_cack[ack_m] = 1'b1; c_rd = !we_m; c_val = ref_w[idx_m];
          end
          if (we_m) ref_w[idx_m] = wd_m;
          m_free = ack_m + 1;
        end
      end
    end
    cpu_req = 1'b0; dma_req = 1'b0;
    tick;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
